// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer for the 4-bit x 4096 main RAM (A = instruction fetch, B = load/store).
// Define ARB_RR_EN for round-robin tie-breaking; the default build gives port A fixed priority. RD_LAT must be >= 1.
module ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out,
  output logic [1:0]        dbg_state_o
);
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              win_b_q, win_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ram_read_q, ram_read_d;
  logic              ram_write_q, ram_write_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_in_q, ram_in_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic              pick_b;

`ifdef ARB_RR_EN
  // last_b_q = 1 means B won the most recent grant; a tie goes to the other port.
  logic last_b_q, last_b_d;

  assign pick_b = req_b & (~req_a | ~last_b_q);

  always_comb begin
    last_b_d = last_b_q;
    if (state_q == IDLE && (req_a || req_b)) begin
      last_b_d = pick_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`else
  assign pick_b = req_b & ~req_a;
`endif

  always_comb begin
    state_d     = state_q;
    win_b_d     = win_b_q;
    cnt_d       = cnt_q;
    ram_read_d  = ram_read_q;
    ram_write_d = ram_write_q;
    ram_addr_d  = ram_addr_q;
    ram_in_d    = ram_in_q;
    rdata_a_d   = rdata_a_q;
    rdata_b_d   = rdata_b_q;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          win_b_d     = pick_b;
          ram_write_d = pick_b ? we_b : we_a;
          ram_read_d  = pick_b ? ~we_b : ~we_a;
          ram_addr_d  = pick_b ? addr_b : addr_a;
          ram_in_d    = pick_b ? wdata_b : wdata_a;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        ram_read_d  = 1'b0;
        ram_write_d = 1'b0;
        if (ram_write_q) begin
          state_d = ACK;
          ack_a_d = ~win_b_q;
          ack_b_d = win_b_q;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      WAIT: begin
        // ram_out is valid on the edge that ends the last WAIT cycle.
        if (cnt_q == '0) begin
          state_d = ACK;
          ack_a_d = ~win_b_q;
          ack_b_d = win_b_q;
          if (win_b_q) begin
            rdata_b_d = ram_out;
          end else begin
            rdata_a_d = ram_out;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_b_q     <= 1'b0;
      cnt_q       <= '0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_in_q    <= '0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_b_q     <= win_b_d;
      cnt_q       <= cnt_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      ram_addr_q  <= ram_addr_d;
      ram_in_q    <= ram_in_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
    end
  end

  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign rdata_a     = rdata_a_q;
  assign rdata_b     = rdata_b_q;
  assign ram_read    = ram_read_q;
  assign ram_write   = ram_write_q;
  assign ram_addr    = ram_addr_q;
  assign ram_in      = ram_in_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a default-latency instance on a behavioural RAM and an RD_LAT=3 instance on a counting ram_out.
// Requester handshake: req is held until the ack cycle and dropped on the edge that ends it.
module tb_ram_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 4;
  localparam int RD_LAT = 1;
`ifdef ARB_RR_EN
  localparam logic [4:0] EXP_ORDER = 5'b11010;  // A B A B B (bit i set = B acked)
  localparam int EXP_A_HELD = 2;
`else
  localparam logic [4:0] EXP_ORDER = 5'b10000;  // A A A A B
  localparam int EXP_A_HELD = 4;
`endif

  logic clk, rst_n;
  logic req_a, we_a, req_b, we_b;
  logic [ADDR_W-1:0] addr_a, addr_b, ram_addr;
  logic [DATA_W-1:0] wdata_a, wdata_b, rdata_a, rdata_b, ram_in, ram_out;
  logic ack_a, ack_b, busy, ram_read, ram_write;
  logic [1:0] dbg_state;

  logic req3, we3, zero1;
  logic [ADDR_W-1:0] addr3, zero_addr, ram_addr3;
  logic [DATA_W-1:0] wdata3, zero_data, rdata3_a, rdata3_b, ram_in3, ctr3;
  logic ack3_a, ack3_b, busy3, ram_read3, ram_write3;
  logic [1:0] dbg3;

  int n_checks = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] exp_a_q[$];
  logic [DATA_W-1:0] exp_b_q[$];
  logic [DATA_W-1:0] exp3_q[$];
  logic [DATA_W-1:0] shadow [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] hold_a = '0;
  logic [DATA_W-1:0] hold_b = '0;
  logic [ADDR_W-1:0] ta, tb;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .ack_b(ack_b), .rdata_b(rdata_b),
    .busy(busy), .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_in(ram_in), .ram_out(ram_out), .dbg_state_o(dbg_state)
  );

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req3), .we_a(we3), .addr_a(addr3), .wdata_a(wdata3), .ack_a(ack3_a), .rdata_a(rdata3_a),
    .req_b(zero1), .we_b(zero1), .addr_b(zero_addr), .wdata_b(zero_data), .ack_b(ack3_b), .rdata_b(rdata3_b),
    .busy(busy3), .ram_read(ram_read3), .ram_write(ram_write3), .ram_addr(ram_addr3),
    .ram_in(ram_in3), .ram_out(ctr3), .dbg_state_o(dbg3)
  );

  // Behavioural RAM with a one-cycle read latency; non-read cycles present 0 on ram_out.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe;
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_in;
    rd_pipe <= ram_read ? mem[ram_addr] : '0;
  end
  assign ram_out = rd_pipe;

  // The RD_LAT=3 instance sees a free-running count, so each cycle's ram_out is distinct.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctr3 <= '0;
    else        ctr3 <= ctr3 + 1'b1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ram_read, ram_write, ram_addr, ram_in, ack_a, ack_b, rdata_a, rdata_b, busy, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h in=%h acks=%b%b rda=%h rdb=%h busy=%b st=%0d, exp all 0",
               ram_read, ram_write, ram_addr, ram_in, ack_a, ack_b, rdata_a, rdata_b, busy, dbg_state);
    end
    n_checks++;
    if ({ram_read3, ram_write3, ack3_a, rdata3_a, busy3} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_lat3: got rd=%b wr=%b ack=%b rda=%h busy=%b, exp all 0",
               ram_read3, ram_write3, ack3_a, rdata3_a, busy3);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One access from a single requester, started in an IDLE cycle; checks latency, strobes and data.
  task automatic txn(input bit pb, input bit we, input logic [ADDR_W-1:0] addr,
                     input logic [DATA_W-1:0] wd, input string tag);
    int lat, n_wr, n_rd, exp_lat;
    bit other_ack, strobe_ok;
    logic [DATA_W-1:0] exp_rd, got_rd, other_hold, other_got;
    if (we) shadow[addr] = wd;
    else if (pb) hold_b = shadow[addr];
    else hold_a = shadow[addr];
    if (pb) exp_b_q.push_back(hold_b);
    else exp_a_q.push_back(hold_a);
    other_hold = pb ? hold_a : hold_b;
    exp_lat = we ? 2 : RD_LAT + 2;
    if (pb) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd; end
    else begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd; end
    lat = 0; n_wr = 0; n_rd = 0; other_ack = 1'b0; strobe_ok = 1'b1;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (ram_write) n_wr++;
      if (ram_read) n_rd++;
      if ((ram_write || ram_read) && (ram_addr !== addr || (we && ram_in !== wd))) strobe_ok = 1'b0;
      if (pb ? ack_a : ack_b) other_ack = 1'b1;
      if (pb ? ack_b : ack_a) break;
    end
    got_rd = pb ? rdata_b : rdata_a;
    other_got = pb ? rdata_a : rdata_b;
    exp_rd = pb ? exp_b_q.pop_front() : exp_a_q.pop_front();
    n_checks++;
    if (lat !== exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d exp %0d", tag, lat, exp_lat); end
    n_checks++;
    if (n_wr !== int'(we) || n_rd !== int'(!we)) begin
      n_fail++; $display("FAIL %s strobes: got wr=%0d rd=%0d exp wr=%0d rd=%0d", tag, n_wr, n_rd, we, !we);
    end
    n_checks++;
    if (!strobe_ok) begin n_fail++; $display("FAIL %s ram_addr/ram_in: got mismatch during strobe exp addr=%h in=%h", tag, addr, wd); end
    n_checks++;
    if (got_rd !== exp_rd) begin n_fail++; $display("FAIL %s rdata: got %h exp %h", tag, got_rd, exp_rd); end
    n_checks++;
    if (other_ack) begin n_fail++; $display("FAIL %s other_ack: got 1 exp 0", tag); end
    n_checks++;
    if (other_got !== other_hold) begin n_fail++; $display("FAIL %s other_rdata: got %h exp %h", tag, other_got, other_hold); end
    if (pb) req_b = 1'b0; else req_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ram_addr !== addr || ram_read || ram_write || busy) begin
      n_fail++; $display("FAIL %s idle_hold: got addr=%h rd=%b wr=%b busy=%b exp addr=%h 0 0 0",
                         tag, ram_addr, ram_read, ram_write, busy, addr);
    end
  endtask

  task automatic test_port_a();
    txn(1'b0, 1'b1, 12'h000, 4'h3, "a_write");
    txn(1'b0, 1'b0, 12'h000, 4'h0, "a_read");
  endtask

  task automatic test_port_b();
    txn(1'b1, 1'b1, 12'h001, 4'h1, "b_write");
    txn(1'b1, 1'b0, 12'h001, 4'h0, "b_read");
  endtask

  task automatic test_tie();
    int cyc, lat_a, lat_b;
    logic [DATA_W-1:0] e;
    ta = 12'($urandom_range(12'h100, 12'h7ff));
    tb = 12'($urandom_range(12'h800, 12'hfff));
    txn(1'b0, 1'b1, ta, 4'($urandom_range(1, 7)), "tie_wr_a");
    txn(1'b1, 1'b1, tb, 4'($urandom_range(8, 15)), "tie_wr_b");
    hold_a = shadow[ta]; exp_a_q.push_back(hold_a);
    hold_b = shadow[tb]; exp_b_q.push_back(hold_b);
    req_a = 1'b1; we_a = 1'b0; addr_a = ta;
    req_b = 1'b1; we_b = 1'b0; addr_b = tb;
    cyc = 0; lat_a = 0; lat_b = 0;
    while ((lat_a == 0 || lat_b == 0) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack_a && lat_a == 0) begin
        lat_a = cyc; req_a = 1'b0; e = exp_a_q.pop_front();
        n_checks++;
        if (rdata_a !== e) begin n_fail++; $display("FAIL tie rdata_a: got %h exp %h", rdata_a, e); end
      end
      if (ack_b && lat_b == 0) begin
        lat_b = cyc; req_b = 1'b0; e = exp_b_q.pop_front();
        n_checks++;
        if (rdata_b !== e) begin n_fail++; $display("FAIL tie rdata_b: got %h exp %h", rdata_b, e); end
      end
    end
    n_checks++;
    if (lat_a !== RD_LAT + 2 || lat_b !== 2 * RD_LAT + 5) begin
      n_fail++; $display("FAIL tie order: got ack_a@%0d ack_b@%0d exp ack_a@%0d ack_b@%0d",
                         lat_a, lat_b, RD_LAT + 2, 2 * RD_LAT + 5);
    end
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
  endtask

  // Both requesters hold req through four acks; then A drops and B's next access must complete.
  task automatic test_held();
    int cyc, n;
    logic [4:0] order;
    logic [DATA_W-1:0] e;
    for (int i = 0; i < EXP_A_HELD; i++) exp_a_q.push_back(shadow[ta]);
    for (int i = 0; i < 5 - EXP_A_HELD; i++) exp_b_q.push_back(shadow[tb]);
    req_a = 1'b1; we_a = 1'b0; addr_a = ta;
    req_b = 1'b1; we_b = 1'b0; addr_b = tb;
    cyc = 0; n = 0; order = '0;
    while (n < 5 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (ack_a || ack_b) begin
        order[n] = ack_b;
        n_checks++;
        if (ack_b ? exp_b_q.size() == 0 : exp_a_q.size() == 0) begin
          n_fail++; $display("FAIL held unexpected_ack: got ack_%s at ack %0d exp none", ack_b ? "b" : "a", n);
        end else begin
          e = ack_b ? exp_b_q.pop_front() : exp_a_q.pop_front();
          if ((ack_b ? rdata_b : rdata_a) !== e) begin
            n_fail++; $display("FAIL held rdata: got %h exp %h", ack_b ? rdata_b : rdata_a, e);
          end
        end
        n++;
        if (n == 4) req_a = 1'b0;
        if (n == 5) req_b = 1'b0;
      end
    end
    n_checks++;
    if (n !== 5 || order !== EXP_ORDER) begin
      n_fail++; $display("FAIL held order: got n=%0d order=%b exp n=5 order=%b", n, order, EXP_ORDER);
    end
    req_a = 1'b0; req_b = 1'b0;
    hold_a = shadow[ta]; hold_b = shadow[tb];
    exp_a_q.delete(); exp_b_q.delete();
    @(negedge clk);
  endtask

  // Request withdrawn and address changed during ACCESS: the latched read still completes.
  task automatic test_withdraw();
    int lat;
    logic [DATA_W-1:0] e;
    hold_a = shadow[ta]; exp_a_q.push_back(hold_a);
    req_a = 1'b1; we_a = 1'b0; addr_a = ta;
    @(negedge clk);
    req_a = 1'b0; addr_a = ~ta;
    lat = 1;
    while (!ack_a && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e = exp_a_q.pop_front();
    n_checks++;
    if (lat !== RD_LAT + 2 || rdata_a !== e || ram_addr !== ta) begin
      n_fail++; $display("FAIL withdraw: got lat=%0d rdata=%h addr=%h exp lat=%0d rdata=%h addr=%h",
                         lat, rdata_a, ram_addr, RD_LAT + 2, e, ta);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    int n_ack;
    req_a = 1'b1; we_a = 1'b0; addr_a = ta;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL rst_mid state_before: got %0d exp 2", dbg_state); end
    rst_n = 1'b0; req_a = 1'b0;
    #1;
    n_checks++;
    if ({ram_read, ram_write, ram_addr, ram_in, ack_a, ack_b, rdata_a, rdata_b, busy} !== '0) begin
      n_fail++; $display("FAIL rst_mid outputs: got addr=%h in=%h rda=%h rdb=%h busy=%b, exp all 0",
                         ram_addr, ram_in, rdata_a, rdata_b, busy);
    end
    hold_a = '0; hold_b = '0;
    @(negedge clk);
    rst_n = 1'b1;
    n_ack = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_a || ack_b) n_ack++;
    end
    n_checks++;
    if (n_ack !== 0) begin n_fail++; $display("FAIL rst_mid ack_after: got %0d exp 0", n_ack); end
    // Reset while the write strobe is up: ram_write must drop at once and nothing is stored.
    req_b = 1'b1; we_b = 1'b1; addr_b = tb; wdata_b = ~shadow[tb];
    @(negedge clk);
    rst_n = 1'b0; req_b = 1'b0;
    #1;
    n_checks++;
    if (ram_write !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_write: got wr=%b busy=%b exp 0 0", ram_write, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    txn(1'b0, 1'b0, ta, 4'h0, "post_rst_read_a");
    txn(1'b1, 1'b0, tb, 4'h0, "post_rst_read_b");
  endtask

  task automatic test_rd_lat3();
    int lat;
    logic [DATA_W-1:0] e;
    for (int k = 0; k < 3; k++) begin
      req3 = 1'b1; we3 = (k == 0); addr3 = 12'($urandom_range(0, 12'hfff)); wdata3 = 4'($urandom_range(0, 15));
      lat = 0;
      while (lat < 20) begin
        @(negedge clk);
        lat++;
        if (ram_read3) exp3_q.push_back(ctr3 + 4'd3);
        if (ack3_a) break;
      end
      n_checks++;
      if (lat !== (we3 ? 2 : 5)) begin n_fail++; $display("FAIL lat3 latency[%0d]: got %0d exp %0d", k, lat, we3 ? 2 : 5); end
      if (!we3) begin
        n_checks++;
        if (exp3_q.size() != 1) begin
          n_fail++; $display("FAIL lat3 read_strobes[%0d]: got %0d exp 1", k, exp3_q.size());
        end else begin
          e = exp3_q.pop_front();
          if (rdata3_a !== e) begin n_fail++; $display("FAIL lat3 rdata[%0d]: got %h exp %h", k, rdata3_a, e); end
        end
      end
      exp3_q.delete();
      req3 = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    req3 = 1'b0; we3 = 1'b0; addr3 = '0; wdata3 = '0;
    zero1 = 1'b0; zero_addr = '0; zero_data = '0;
    test_reset();
    test_port_a();
    test_port_b();
    test_tie();
    test_held();
    test_withdraw();
    test_reset_mid_access();
    test_rd_lat3();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the 4-bit x 4096 main RAM.
- Port A is the instruction-fetch side; port B is the data (load/store) side.
- Grants one access at a time and drives the RAM's read/write/addr/in pins from registered outputs.
- Captures read data and returns a one-cycle ack to the winning requester.

Parameters:
- ADDR_W, 12: RAM address width.
- DATA_W, 4: RAM data width.
- RD_LAT, 1: cycles from the edge sampling ram_read=1 until ram_out is valid; must be >= 1.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_a  input  1  port A request, held until ack_a
- we_a  input  1  port A write enable (1 = write, 0 = read)
- addr_a  input  ADDR_W  port A address
- wdata_a  input  DATA_W  port A write data
- ack_a  output  1  port A one-cycle completion pulse
- rdata_a  output  DATA_W  port A read data; valid in the ack cycle, held until the next port A read ack
- req_b, we_b, addr_b, wdata_b, ack_b, rdata_b: same as port A, for port B
- busy  output  1  high whenever the state is not IDLE
- ram_read  output  1  RAM read strobe
- ram_write  output  1  RAM write strobe
- ram_addr  output  ADDR_W  RAM address
- ram_in  output  DATA_W  RAM write data
- ram_out  input  DATA_W  RAM read data

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0: ram_read, ram_write, ram_addr, ram_in, ack_a, ack_b, rdata_a, rdata_b, busy.
  - A reset in mid-access aborts the access; ram_write falls immediately and no ack is issued.
- FSM states: IDLE, ACCESS, WAIT, ACK.
- IDLE:
  - Samples req_a/req_b.
  - On any request, picks a winner and latches its we/addr/wdata into ram_write/ram_read/ram_addr/ram_in.
  - Goes to ACCESS.
- ACCESS, exactly 1 cycle:
  - Exactly one of ram_write or ram_read is high; ram_addr and ram_in are stable.
  - Write: go to ACK.
  - Read: go to WAIT.
  - Strobes drop on exit.
- WAIT, RD_LAT cycles:
  - Counter counts down.
  - On the edge ending the last WAIT cycle, ram_out is loaded into the winner's rdata register.
  - Goes to ACK.
- ACK, 1 cycle:
  - Winner's ack is high.
  - req inputs are ignored.
  - Goes to IDLE.
- Requester protocol:
  - The requester drops req on the edge ending its ack cycle.
  - A req still high in the following IDLE cycle is a new request.
- Latency, measured from the IDLE cycle that sees req:
  - Write: ack at +2 cycles.
  - Read: ack at +(RD_LAT+2) cycles, i.e. +3 at the default.
- Request withdrawn before ack: the latched access still completes and the ack still pulses.
- Request inputs are sampled only in IDLE; changes during an access have no effect on it.
- The non-winning requester's rdata is never modified.
- ram_addr and ram_in keep their last values when idle; only the strobes return to 0.
- Back-to-back throughput: at most one write per 3 cycles and one read per RD_LAT+3 cycles.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined (round-robin):
  - A last_grant flag is updated on each grant; reset value is B.
  - When both requests are high, the grant goes to the port not granted last, so A wins the first tie.
  - A single requester is always granted.
- Undefined (fixed priority):
  - Port A always wins a tie.
  - The last_grant logic is not built.

Test Plan:
- Write then read, port A alone: write 0x3 to addr 0x000 (ack_a 2 cycles after req_a, ram_write high 1 cycle, ram_in=0x3); read addr 0x000 -> ack_a at +3, rdata_a=0x3, ram_read high 1 cycle.
- Port B alone, write 0x1 at addr 0x001 then read addr 0x001: rdata_b=0x1, rdata_a unchanged, ack_a never high.
- Tie: req_a and req_b high together, both reading different addrs:
  - Fixed priority: A acked first, then B.
  - ARB_RR_EN, both reqs held high for four transactions: order A, B, A, B.
- Fixed mode starvation check: req_a held continuously -> B never acked while A is re-requesting; once req_a drops, B completes.
- Reset mid-read (rst_n low during WAIT): all outputs 0 immediately; no ack after release; next request works normally.
- RD_LAT=3 build: read ack at +5 cycles; the captured value equals ram_out 3 cycles after the ram_read sample edge.
